// File: rtl/ntt_pkg.sv
// Shared types for the NTT/INTT datapath: coefficient type, lane count and
// the operand-pair slot record used by the pair loader.
package ntt_pkg;

    localparam int HALF_NUM_BFU = 16;
    localparam int LANES        = 2 * HALF_NUM_BFU;

    typedef logic [15:0] coeff_t;

    typedef struct packed {
        coeff_t [LANES-1:0] a;
        coeff_t [LANES-1:0] b;
        logic               intt;
        logic               permute;
    } pair_slot_t;

endpackage

// File: rtl/ntt_pair_loader.sv
// Double-buffered (A, B) operand pair stager ahead of the INTT permute network.
// Consecutive input words are paired; the A word carries the intt/permute
// flags. Two slots let the next pair fill while the current one is stalled.
// Optional feature: define NTT_PAIR_LOADER_FLUSH_EN to add the i_flush port,
// which clears pointers/count/phase (slot data kept) with priority over
// accept and pop.
module ntt_pair_loader
    import ntt_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef NTT_PAIR_LOADER_FLUSH_EN
    input  logic               i_flush,
`endif
    input  logic               i_word_valid,
    output logic               o_word_ready,
    input  coeff_t [LANES-1:0] i_word,
    input  logic               i_word_intt,
    input  logic               i_word_permute,
    output logic               o_pair_valid,
    input  logic               i_pair_ready,
    output coeff_t [LANES-1:0] o_a,
    output coeff_t [LANES-1:0] o_b,
    output logic               o_intt,
    output logic               o_permute
);

    pair_slot_t slot_q [2];
    logic       wp_q;
    logic       rp_q;
    logic       ph_q;
    logic [1:0] cnt_q;

    logic flush;
    logic accept;
    logic complete;
    logic pop;

`ifdef NTT_PAIR_LOADER_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Ready depends only on registered count, so no path from i_pair_ready.
    assign o_word_ready = (cnt_q != 2'd2);
    assign o_pair_valid = (cnt_q != 2'd0);

    assign accept   = i_word_valid & o_word_ready & ~flush;
    assign complete = accept & ph_q;
    assign pop      = o_pair_valid & i_pair_ready & ~flush;

    assign o_a       = slot_q[rp_q].a;
    assign o_b       = slot_q[rp_q].b;
    assign o_intt    = slot_q[rp_q].intt;
    assign o_permute = slot_q[rp_q].permute;

    // Pointer, phase and occupancy tracking; flush clears like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            ph_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (accept) begin
                ph_q <= ~ph_q;
            end
            if (complete) begin
                wp_q <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            if (complete && !pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !complete) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    // Slot storage: A word latches the pair flags, B word finishes the pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
        end else if (accept) begin
            if (!ph_q) begin
                slot_q[wp_q].a       <= i_word;
                slot_q[wp_q].intt    <= i_word_intt;
                slot_q[wp_q].permute <= i_word_permute;
            end else begin
                slot_q[wp_q].b <= i_word;
            end
        end
    end

endmodule

// File: tb/tb_ntt_pair_loader.sv
// Self-checking bench for ntt_pair_loader: table-driven directed sequence,
// hand-written reset/flush sequences and randomized traffic against a
// queue-based pair model.
module tb_ntt_pair_loader;
    import ntt_pkg::*;

    typedef coeff_t [LANES-1:0] word_t;

    typedef struct {
        word_t a;
        word_t b;
        logic  intt;
        logic  permute;
    } pair_t;

    typedef struct {
        logic        v;
        logic [15:0] base;
        logic        fi;
        logic        fp;
        logic        rdy;
        logic        exp_valid;
        logic        exp_ready;
        logic        exp_intt;
        logic        exp_perm;
        logic [15:0] exp_a0;
        logic [15:0] exp_b31;
    } vec_t;

    logic  i_clk = 1'b0;
    logic  i_rst;
    logic  i_word_valid;
    logic  o_word_ready;
    word_t i_word;
    logic  i_word_intt;
    logic  i_word_permute;
    logic  o_pair_valid;
    logic  i_pair_ready;
    word_t o_a;
    word_t o_b;
    logic  o_intt;
    logic  o_permute;
`ifdef NTT_PAIR_LOADER_FLUSH_EN
    logic  i_flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pair_t mq[$];
    pair_t half;
    bit    have_half;

    always #5 i_clk = ~i_clk;

    ntt_pair_loader dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
`ifdef NTT_PAIR_LOADER_FLUSH_EN
        .i_flush        (i_flush),
`endif
        .i_word_valid   (i_word_valid),
        .o_word_ready   (o_word_ready),
        .i_word         (i_word),
        .i_word_intt    (i_word_intt),
        .i_word_permute (i_word_permute),
        .o_pair_valid   (o_pair_valid),
        .i_pair_ready   (i_pair_ready),
        .o_a            (o_a),
        .o_b            (o_b),
        .o_intt         (o_intt),
        .o_permute      (o_permute)
    );

    function automatic word_t mk_word(input logic [15:0] base);
        word_t w;
        for (int i = 0; i < LANES; i++) w[i] = base + 16'(i);
        return w;
    endfunction

    function automatic word_t rnd_word();
        word_t w;
        for (int i = 0; i < LANES; i++) w[i] = 16'($urandom);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("pair_valid", 512'(o_pair_valid), 512'(mq.size() != 0));
        chk("word_ready", 512'(o_word_ready), 512'(mq.size() != 2));
        if (mq.size() != 0) begin
            chk("a", o_a, mq[0].a);
            chk("b", o_b, mq[0].b);
            chk("intt", 512'(o_intt), 512'(mq[0].intt));
            chk("permute", 512'(o_permute), 512'(mq[0].permute));
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit later.
    task automatic step(input logic v, input word_t w, input logic fi, input logic fp,
                        input logic rdy, input logic rst, input logic fl);
        bit acc;
        bit pop;
        i_word_valid   = v;
        i_word         = w;
        i_word_intt    = fi;
        i_word_permute = fp;
        i_pair_ready   = rdy;
        i_rst          = rst;
`ifdef NTT_PAIR_LOADER_FLUSH_EN
        i_flush        = fl;
`endif
        acc = v && (mq.size() != 2);
        pop = rdy && (mq.size() != 0);
        @(posedge i_clk);
        if (rst || fl) begin
            mq.delete();
            have_half = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (!have_half) begin
                    half.a       = w;
                    half.intt    = fi;
                    half.permute = fp;
                    have_half    = 1;
                end else begin
                    half.b = w;
                    mq.push_back(half);
                    have_half = 0;
                end
            end
        end
        #1;
        check_model();
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0120};
        tbl[2] = '{1'b1, 16'h0201, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0120};
        tbl[3] = '{1'b1, 16'h0301, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0120};
        tbl[4] = '{1'b1, 16'h0401, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0120};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0201, 16'h0320};
        tbl[6] = '{1'b1, 16'h0401, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0201, 16'h0320};
        tbl[7] = '{1'b1, 16'h0501, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0401, 16'h0520};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};

        have_half = 0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_a", o_a, '0);
        chk("reset_b", o_b, '0);
        chk("reset_intt", 512'(o_intt), 512'(0));
        chk("reset_permute", 512'(o_permute), 512'(0));
        chk("reset_valid", 512'(o_pair_valid), 512'(0));
        chk("reset_ready", 512'(o_word_ready), 512'(1));

        // Fill, backpressure, flag capture, complete+pop in one cycle, drain.
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].v, mk_word(tbl[k].base), tbl[k].fi, tbl[k].fp, tbl[k].rdy, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", k), 512'(o_pair_valid), 512'(tbl[k].exp_valid));
            chk($sformatf("tbl%0d_ready", k), 512'(o_word_ready), 512'(tbl[k].exp_ready));
            if (tbl[k].exp_valid) begin
                chk($sformatf("tbl%0d_a0", k), 512'(o_a[0]), 512'(tbl[k].exp_a0));
                chk($sformatf("tbl%0d_b31", k), 512'(o_b[LANES-1]), 512'(tbl[k].exp_b31));
                chk($sformatf("tbl%0d_intt", k), 512'(o_intt), 512'(tbl[k].exp_intt));
                chk($sformatf("tbl%0d_perm", k), 512'(o_permute), 512'(tbl[k].exp_perm));
            end
        end

        // Reset with one pair held and a half pair pending.
        step(1'b1, mk_word(16'h1000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_word(16'h1100), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_word(16'h1200), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_half_valid", 512'(o_pair_valid), 512'(0));
        chk("rst_half_ready", 512'(o_word_ready), 512'(1));
        step(1'b1, mk_word(16'h2000), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_word(16'h2100), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_fresh_a0", 512'(o_a[0]), 512'(16'h2000));
        chk("rst_fresh_intt", 512'(o_intt), 512'(0));

        // Reset with both slots full.
        step(1'b1, mk_word(16'h2200), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_word(16'h2300), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 512'(o_word_ready), 512'(0));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_full_valid", 512'(o_pair_valid), 512'(0));
        chk("rst_full_ready", 512'(o_word_ready), 512'(1));

`ifdef NTT_PAIR_LOADER_FLUSH_EN
        // Flush coinciding with a B-word accept drops the pair.
        step(1'b1, mk_word(16'h3000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_word(16'h3100), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", 512'(o_pair_valid), 512'(0));
        step(1'b1, mk_word(16'h3200), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_no_pair", 512'(o_pair_valid), 512'(0));
        step(1'b1, mk_word(16'h3300), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_new_a0", 512'(o_a[0]), 512'(16'h3200));
        chk("flush_new_b0", 512'(o_b[0]), 512'(16'h3300));
`endif

        // Randomized traffic against the pair-queue model.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_word(), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0),
`ifdef NTT_PAIR_LOADER_FLUSH_EN
                 1'($urandom_range(0, 99) == 0)
`else
                 1'b0
`endif
                 );
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
